uart_alici: RTL and testbench

//   Serial UART receiver (8N1, LSB first), the downstream peer of the UART transmitter.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_alici_if.sv | 21 ++
 rtl/uart_senkron.sv | 27 ++
 rtl/uart_alici.sv | 134 +++++++++++++
 tb/tb_uart_alici.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, bit-period defaults, data width.
// Build option: FAST_UART selects the short bit period used for simulation.
package uart_pkg;

  typedef enum logic [2:0] {
    BOSTA = 3'd0,
    BASLA = 3'd1,
    AL    = 3'd2,
    DUR   = 3'd3,
    BEKLE = 3'd4
  } uart_durum_t;

`ifdef FAST_UART
  localparam int unsigned UART_SAAT_VARSAYILAN = 16;
`else
  // 9600 bps at 50 MHz
  localparam int unsigned UART_SAAT_VARSAYILAN = 5208;
`endif

  localparam int unsigned VERI_GENISLIK = 8;

endpackage

// File: rtl/uart_alici_if.sv
// Byte output handshake and status of the UART receiver.
// Build option: UART_RX_CERCEVE_HATA_EN adds the cerceve_hata status line.
interface uart_alici_if;
  import uart_pkg::*;

  logic [VERI_GENISLIK-1:0] al_veri;
  logic                     al_gecerli;
  logic                     al_hazir;
  logic                     tasma;
  logic                     mesgul;
`ifdef UART_RX_CERCEVE_HATA_EN
  logic                     cerceve_hata;

  modport master (output al_veri, al_gecerli, tasma, mesgul, cerceve_hata, input al_hazir);
  modport slave  (input al_veri, al_gecerli, tasma, mesgul, cerceve_hata, output al_hazir);
`else
  modport master (output al_veri, al_gecerli, tasma, mesgul, input al_hazir);
  modport slave  (input al_veri, al_gecerli, tasma, mesgul, output al_hazir);
`endif

endinterface

// File: rtl/uart_senkron.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
module uart_senkron #(
  parameter logic RESET_DEGER = 1'b1
) (
  input  logic clk_g,
  input  logic rst_g,
  input  logic d,
  output logic q
);

  logic ff1_q;
  logic ff2_q;

  // Two-stage capture; both stages reset to the line's idle level
  always_ff @(posedge clk_g) begin
    if (!rst_g) begin
      ff1_q <= RESET_DEGER;
      ff2_q <= RESET_DEGER;
    end else begin
      ff1_q <= d;
      ff2_q <= ff1_q;
    end
  end

  assign q = ff2_q;

endmodule

// File: rtl/uart_alici.sv
// UART receiver, 8N1 LSB first, with a one-entry output holding register.
// Build option: UART_RX_CERCEVE_HATA_EN enables the cerceve_hata pulse on a bad stop bit.
module uart_alici
  import uart_pkg::*;
#(
  parameter int unsigned UART_SAAT = UART_SAAT_VARSAYILAN
) (
  input  logic         clk_g,
  input  logic         rst_g,
  input  logic         RX,
  uart_alici_if.master al
);

  localparam int unsigned SW = $clog2(UART_SAAT + 1);
  localparam logic [SW-1:0] SON  = SW'(UART_SAAT);
  localparam logic [SW-1:0] YARI = SW'(UART_SAAT / 2);

  logic rx_s;

  uart_senkron #(
    .RESET_DEGER(1'b1)
  ) u_senkron (
    .clk_g(clk_g),
    .rst_g(rst_g),
    .d    (RX),
    .q    (rx_s)
  );

  uart_durum_t              durum_q, durum_d;
  logic [SW-1:0]            sayac_q, sayac_d;
  logic [2:0]               idx_q, idx_d;
  logic [VERI_GENISLIK-1:0] sr_q, sr_d;
  logic [VERI_GENISLIK-1:0] veri_q, veri_d;
  logic                     gecerli_q, gecerli_d;
  logic                     tasma_q, tasma_d;
  logic                     son;
  logic                     teslim;
`ifdef UART_RX_CERCEVE_HATA_EN
  logic                     hata_q, hata_d;
`endif

  // Frame FSM, bit counter and output holding register next-state
  always_comb begin
    durum_d   = durum_q;
    idx_d     = idx_q;
    sr_d      = sr_q;
    veri_d    = veri_q;
    gecerli_d = gecerli_q;
    tasma_d   = 1'b0;
    teslim    = 1'b0;
`ifdef UART_RX_CERCEVE_HATA_EN
    hata_d    = 1'b0;
`endif
    son       = (sayac_q == SON);

    unique case (durum_q)
      BOSTA: if (!rx_s) durum_d = BASLA;
      // Half a bit in: confirms the start bit and sets the mid-bit sampling phase
      BASLA: if (sayac_q == YARI) durum_d = rx_s ? BOSTA : AL;
      AL: begin
        if (son) begin
          sr_d[idx_q] = rx_s;
          idx_d       = idx_q + 3'd1;
          if (idx_q == 3'd7) durum_d = DUR;
        end
      end
      DUR: begin
        if (son) begin
          if (rx_s) begin
            durum_d = BOSTA;
            teslim  = 1'b1;
          end else begin
            durum_d = BEKLE;
`ifdef UART_RX_CERCEVE_HATA_EN
            hata_d  = 1'b1;
`endif
          end
        end
      end
      // Hold off until the line returns high so a break cannot look like a new start bit
      BEKLE: if (rx_s) durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase

    if (durum_d != durum_q || durum_q == BOSTA || son) sayac_d = '0;
    else                                                 sayac_d = sayac_q + 1'b1;

    if (gecerli_q && al.al_hazir) gecerli_d = 1'b0;
    if (teslim) begin
      if (!gecerli_q || al.al_hazir) begin
        veri_d    = sr_q;
        gecerli_d = 1'b1;
      end else begin
        tasma_d   = 1'b1;
      end
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk_g) begin
    if (!rst_g) begin
      durum_q   <= BOSTA;
      sayac_q   <= '0;
      idx_q     <= '0;
      sr_q      <= '0;
      veri_q    <= '0;
      gecerli_q <= 1'b0;
      tasma_q   <= 1'b0;
`ifdef UART_RX_CERCEVE_HATA_EN
      hata_q    <= 1'b0;
`endif
    end else begin
      durum_q   <= durum_d;
      sayac_q   <= sayac_d;
      idx_q     <= idx_d;
      sr_q      <= sr_d;
      veri_q    <= veri_d;
      gecerli_q <= gecerli_d;
      tasma_q   <= tasma_d;
`ifdef UART_RX_CERCEVE_HATA_EN
      hata_q    <= hata_d;
`endif
    end
  end

  assign al.al_veri    = veri_q;
  assign al.al_gecerli = gecerli_q;
  assign al.tasma      = tasma_q;
  assign al.mesgul     = (durum_q != BOSTA);
`ifdef UART_RX_CERCEVE_HATA_EN
  assign al.cerceve_hata = hata_q;
`endif

endmodule

// File: tb/tb_uart_alici.sv
// Directed bench for uart_alici with a 17-clock bit period.
module tb_uart_alici;

  localparam int BIT   = 17;
  localparam int FRAME = 10 * BIT;

  logic clk_g = 1'b0;
  logic rst_g = 1'b0;
  logic RX    = 1'b1;

  int checks = 0;
  int errors = 0;

  uart_alici_if al ();

  uart_alici #(
    .UART_SAAT(16)
  ) dut (
    .clk_g(clk_g),
    .rst_g(rst_g),
    .RX   (RX),
    .al   (al)
  );

  always #5 clk_g = ~clk_g;

  // Passive monitor: consumed bytes, pulse counts, cycle count
  logic [7:0] alinan[$];
  int tasma_say   = 0;
  int hata_say    = 0;
  int gecerli_say = 0;
  int cyc         = 0;
  int yukselis    = -1;
  logic gecerli_prev = 1'b0;

  always @(negedge clk_g) begin
    cyc = cyc + 1;
    if (rst_g) begin
      if (al.al_gecerli && al.al_hazir) alinan.push_back(al.al_veri);
      if (al.tasma) tasma_say = tasma_say + 1;
      if (al.al_gecerli) gecerli_say = gecerli_say + 1;
      if (al.al_gecerli && !gecerli_prev) yukselis = cyc;
`ifdef UART_RX_CERCEVE_HATA_EN
      if (al.cerceve_hata) hata_say = hata_say + 1;
`endif
    end
    gecerli_prev = al.al_gecerli;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_g);
    #1;
  endtask

  // Drives frame slots [from, to): slot 0..16 start, then 8 data bits, then stop
  task automatic drive_frame(input logic [7:0] b, input logic stop, input int from, input int to);
    for (int c = from; c < to; c++) begin
      int k;
      k = c / BIT;
      @(posedge clk_g);
      #1;
      if (k == 0)      RX = 1'b0;
      else if (k <= 8) RX = b[k-1];
      else             RX = stop;
    end
  endtask

  task automatic send(input logic [7:0] b);
    drive_frame(b, 1'b1, 0, FRAME);
    RX = 1'b1;
  endtask

  task automatic test_reset();
    rst_g = 1'b0;
    al.al_hazir = 1'b0;
    idle(3);
    @(negedge clk_g);
    checks++; if (al.al_veri !== 8'h00) begin errors++; $display("FAIL reset_veri got %h want 00", al.al_veri); end
    checks++; if (al.al_gecerli !== 1'b0) begin errors++; $display("FAIL reset_gecerli got %b want 0", al.al_gecerli); end
    checks++; if (al.tasma !== 1'b0) begin errors++; $display("FAIL reset_tasma got %b want 0", al.tasma); end
    checks++; if (al.mesgul !== 1'b0) begin errors++; $display("FAIL reset_mesgul got %b want 0", al.mesgul); end
`ifdef UART_RX_CERCEVE_HATA_EN
    checks++; if (al.cerceve_hata !== 1'b0) begin errors++; $display("FAIL reset_hata got %b want 0", al.cerceve_hata); end
`endif
    @(posedge clk_g); #1;
    rst_g = 1'b1;
    idle(5);
  endtask

  task automatic test_frame_a5();
    int n0, t0, g0, s, lat;
    al.al_hazir = 1'b1;
    n0 = alinan.size(); t0 = tasma_say; g0 = gecerli_say;
    @(negedge clk_g); #1;
    s = cyc;
    send(8'hA5);
    idle(10);
    @(negedge clk_g);
    lat = yukselis - s;
    checks++; if (alinan.size() != n0 + 1) begin errors++; $display("FAIL a5_count got %0d want %0d", alinan.size() - n0, 1); end
    else begin
      checks++; if (alinan[n0] !== 8'hA5) begin errors++; $display("FAIL a5_veri got %h want a5", alinan[n0]); end
    end
    checks++; if (gecerli_say - g0 != 1) begin errors++; $display("FAIL a5_gecerli_cycles got %0d want 1", gecerli_say - g0); end
    checks++; if (tasma_say != t0) begin errors++; $display("FAIL a5_tasma got %0d want 0", tasma_say - t0); end
    checks++; if (al.mesgul !== 1'b0) begin errors++; $display("FAIL a5_mesgul got %b want 0", al.mesgul); end
    checks++; if (lat < 160 || lat > 170) begin errors++; $display("FAIL a5_latency got %0d want 160..170", lat); end
  endtask

  task automatic test_glitch();
    int n0, busy;
    n0 = alinan.size();
    busy = 0;
    RX = 1'b0;
    idle(4);
    RX = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_g);
      if (al.mesgul) busy++;
    end
    checks++; if (busy == 0 || busy >= 12) begin errors++; $display("FAIL glitch_mesgul_cycles got %0d want 1..11", busy); end
    checks++; if (alinan.size() != n0 || al.al_gecerli !== 1'b0) begin
      errors++; $display("FAIL glitch_output got %0d bytes gecerli %b want 0 bytes gecerli 0", alinan.size() - n0, al.al_gecerli);
    end
    checks++; if (al.mesgul !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b want 0", al.mesgul); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    int n0, t0;
    al.al_hazir = 1'b1;
    n0 = alinan.size(); t0 = tasma_say;
    send(8'h00);
    send(8'hFF);
    idle(10);
    checks++; if (alinan.size() != n0 + 2) begin errors++; $display("FAIL b2b_count got %0d want 2", alinan.size() - n0); end
    else begin
      checks++; if (alinan[n0] !== 8'h00) begin errors++; $display("FAIL b2b_first got %h want 00", alinan[n0]); end
      checks++; if (alinan[n0+1] !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h want ff", alinan[n0+1]); end
    end
    checks++; if (tasma_say != t0) begin errors++; $display("FAIL b2b_tasma got %0d want 0", tasma_say - t0); end
  endtask

  task automatic test_overrun();
    int n0, t0;
    al.al_hazir = 1'b0;
    n0 = alinan.size(); t0 = tasma_say;
    send(8'h3C);
    send(8'hC3);
    idle(10);
    @(negedge clk_g);
    checks++; if (al.al_gecerli !== 1'b1) begin errors++; $display("FAIL ovr_gecerli got %b want 1", al.al_gecerli); end
    checks++; if (al.al_veri !== 8'h3C) begin errors++; $display("FAIL ovr_veri got %h want 3c", al.al_veri); end
    checks++; if (tasma_say - t0 != 1) begin errors++; $display("FAIL ovr_tasma got %0d want 1", tasma_say - t0); end
    @(posedge clk_g); #1;
    al.al_hazir = 1'b1;
    idle(1);
    al.al_hazir = 1'b0;
    idle(5);
    @(negedge clk_g);
    checks++; if (al.al_gecerli !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", al.al_gecerli); end
    checks++; if (alinan.size() != n0 + 1) begin errors++; $display("FAIL ovr_count got %0d want 1", alinan.size() - n0); end
    else begin
      checks++; if (alinan[n0] !== 8'h3C) begin errors++; $display("FAIL ovr_taken got %h want 3c", alinan[n0]); end
    end
    al.al_hazir = 1'b1;
  endtask

  task automatic test_frame_error();
    int n0, h0;
    al.al_hazir = 1'b1;
    n0 = alinan.size(); h0 = hata_say;
    drive_frame(8'h55, 1'b0, 0, FRAME);
    idle(30);
    RX = 1'b1;
    idle(10);
    @(negedge clk_g);
    checks++; if (alinan.size() != n0) begin errors++; $display("FAIL ferr_output got %0d bytes want 0", alinan.size() - n0); end
    checks++; if (al.mesgul !== 1'b0) begin errors++; $display("FAIL ferr_mesgul got %b want 0", al.mesgul); end
`ifdef UART_RX_CERCEVE_HATA_EN
    checks++; if (hata_say - h0 != 1) begin errors++; $display("FAIL ferr_hata got %0d want 1", hata_say - h0); end
`endif
    send(8'h12);
    idle(10);
    checks++; if (alinan.size() != n0 + 1) begin errors++; $display("FAIL ferr_next_count got %0d want 1", alinan.size() - n0); end
    else begin
      checks++; if (alinan[n0] !== 8'h12) begin errors++; $display("FAIL ferr_next got %h want 12", alinan[n0]); end
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    al.al_hazir = 1'b0;
    send(8'h5A);
    idle(5);
    n0 = alinan.size();
    // 0xF3: bits 4..7 and stop are high, so the tail after reset is idle line
    drive_frame(8'hF3, 1'b1, 0, 5 * BIT + 8);
    @(negedge clk_g);
    checks++; if (al.mesgul !== 1'b1 || al.al_gecerli !== 1'b1) begin
      errors++; $display("FAIL rmid_before got mesgul %b gecerli %b want 1 1", al.mesgul, al.al_gecerli);
    end
    @(posedge clk_g); #1;
    rst_g = 1'b0;
    @(posedge clk_g);
    @(negedge clk_g);
    checks++; if (al.al_veri !== 8'h00 || al.al_gecerli !== 1'b0 || al.tasma !== 1'b0 || al.mesgul !== 1'b0) begin
      errors++; $display("FAIL rmid_outputs got veri %h gecerli %b tasma %b mesgul %b want 00 0 0 0",
                         al.al_veri, al.al_gecerli, al.tasma, al.mesgul);
    end
    @(posedge clk_g); #1;
    rst_g = 1'b1;
    al.al_hazir = 1'b1;
    drive_frame(8'hF3, 1'b1, 5 * BIT + 11, FRAME);
    RX = 1'b1;
    idle(20);
    @(negedge clk_g);
    checks++; if (alinan.size() != n0 || al.al_gecerli !== 1'b0) begin
      errors++; $display("FAIL rmid_spurious got %0d bytes gecerli %b want 0 bytes gecerli 0", alinan.size() - n0, al.al_gecerli);
    end
    checks++; if (al.mesgul !== 1'b0) begin errors++; $display("FAIL rmid_mesgul got %b want 0", al.mesgul); end
  endtask

  task automatic test_loopback();
    int n0, t0;
    al.al_hazir = 1'b1;
    n0 = alinan.size(); t0 = tasma_say;
    for (int i = 0; i < 256; i++) send(8'(i));
    idle(10);
    checks++; if (alinan.size() != n0 + 256) begin errors++; $display("FAIL loop_count got %0d want 256", alinan.size() - n0); end
    else begin
      for (int i = 0; i < 256; i++) begin
        checks++; if (alinan[n0+i] !== 8'(i)) begin errors++; $display("FAIL loop_byte%0d got %h want %h", i, alinan[n0+i], 8'(i)); end
      end
    end
    checks++; if (tasma_say != t0) begin errors++; $display("FAIL loop_tasma got %0d want 0", tasma_say - t0); end
  endtask

  initial begin
    al.al_hazir = 1'b0;
    test_reset();
    test_frame_a5();
    test_glitch();
    test_back_to_back();
    test_overrun();
    test_frame_error();
    test_reset_mid();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
